pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined N-bit adder/subtractor for datapaths where a single ripple chain across the full width cannot close timing.
- The carry chain is split into STAGES equal segments, one register stage each.
- Operands move through the pipeline with a valid/ready handshake.
- Adds a subtract mode and a signed-overflow flag alongside the unsigned carry-out.

Parameters:
N, 16, operand/result width in bits; N mod STAGES must be 0.
STAGES, 4, pipeline depth and number of carry-chain segments (1..N); segment width W = N/STAGES.

Ports:
clk  input  1  rising-edge clock; one clock domain.
rst_n  input  1  reset, asynchronous assert, active-low.
in_valid  input  1  x, y, c_in, sub are valid this cycle.
in_ready  output  1  block accepts the input this cycle.
x  input  N  operand A.
y  input  N  operand B.
c_in  input  1  carry-in in add mode; borrow-in in subtract mode.
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  s, c_out, ovf hold a result.
out_ready  input  1  consumer accepts the result.
s  output  N  sum/difference.
c_out  output  1  carry-out; in subtract mode this is NOT-borrow.
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear; out_valid=0, s=0, c_out=0, ovf=0; in_ready=1 once rst_n is high.
- Operand conditioning at input: ye = y XOR {N{sub}}; ce = c_in XOR sub.
  - Add: s = x + y + c_in.
  - Subtract: s = x - y - c_in.
- Stage k (0..STAGES-1) ripples bits [k*W +: W] using the carry registered by stage k-1. Stage 0 uses ce.
- Unprocessed upper operand bits and completed lower sum bits travel in skew registers alongside each stage. No combinational path spans more than one W-bit segment.
- Global advance: en = !out_valid || out_ready; in_ready = en.
  - When en=1, every stage register (data and valid) loads from its predecessor.
  - Stage 0 valid loads (in_valid && in_ready).
  - When en=0, all stages hold.
  - Bubbles advance whenever en=1, so no bubble collapsing is required.
- Latency: STAGES cycles from the accepting edge to out_valid=1, given out_ready stays high.
- Throughput: one result per cycle.
- Outputs are registered, and s, c_out, ovf are stable while out_valid=1 and out_ready=0.
- c_out is the carry out of bit N-1 of x + ye + ce.
- ovf = carry into bit N-1 XOR carry out of bit N-1, evaluated in the final stage. The carry into bit N-1 is taken inside the last segment.
- sub and c_in are captured at acceptance and never re-sampled downstream.
- Simultaneous accept and drain at full occupancy is legal when out_ready=1; no data is lost or duplicated.
- Result order equals acceptance order.
- Reset mid-operation discards all in-flight results; no output appears after reset deasserts until new inputs are accepted.
- STAGES=1 degenerates to one full-width ripple with a single output register (latency 1).
- STAGES=N gives 1-bit segments.
- in_valid is ignored while in_ready=0, and x/y/c_in/sub are don't-care while in_valid=0.

Test Plan:
(N=16, STAGES=4 unless noted)
1. Add carry chain: x=0xFFFF, y=0x0001, c_in=0, sub=0, out_ready=1 -> 4 cycles later s=0x0000, c_out=1, ovf=0.
2. Signed overflow: x=0x7FFF, y=0x0001, add -> s=0x8000, c_out=0, ovf=1. Then x=0x8000, y=0xFFFF, add -> s=0x7FFF, c_out=1, ovf=1.
3. Subtract: x=0x0005, y=0x0007, sub=1, c_in=0 -> s=0xFFFE, c_out=0, ovf=0. Same operands with c_in=1 -> s=0xFFFD. x=0x8000, y=0x0001, sub -> s=0x7FFF, ovf=1.
4. Backpressure: stream 10 back-to-back ops x=i, y=i for i=0..9, and hold out_ready=0 for 3 cycles when the first result appears.
   - in_ready=0 during the stall.
   - The output holds s=0x0000.
   - After release, results 0,2,4,...,18 arrive in order with none lost or duplicated.
5. Reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 and s=0 immediately, with no stale result after release. A new op 0x1234+0x1111 then yields 0x2345.
6. Parameter sweep: random 1000 ops at (N,STAGES) = (16,1), (16,16) and (32,4), checked against the reference model x + (sub ? ~y : y) + (c_in ^ sub), including c_out and ovf.

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub
// N-bit adder/subtractor with the carry chain cut into STAGES equal W-bit
// segments. Each stage ripples one segment and registers it. The untouched
// upper operand bits and the finished lower sum bits travel with the stage.
// A single global advance signal moves every stage in lockstep. Bubbles
// advance along with data, so backpressure only has to stall the whole pipe.

module pipelined_addsub #(
   parameter int N      = 16,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         c_in,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         c_out,
   output logic         ovf
);

   localparam int W = N / STAGES;

   logic en_s;

   // The pipe may advance when the output register is empty or being drained.
   assign en_s     = !g_stage[STAGES-1].v_r || out_ready;
   assign in_ready = en_s;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [N-1:0] x_in_s;
      logic [N-1:0] ye_in_s;
      logic [N-1:0] s_in_s;
      logic         c_in_s;
      logic         v_in_s;
      logic [W-1:0] xa_s;
      logic [W-1:0] ya_s;
      logic [W-1:0] seg_s;
      logic [N-1:0] s_next_s;
      logic         msb_carry_s;
      logic         cout_s;
      logic [N-1:0] x_r;
      logic [N-1:0] ye_r;
      logic [N-1:0] s_r;
      logic         c_r;
      logic         ovf_r;
      logic         v_r;
      logic         unused_s;

      if (k == 0) begin : g_head
         // Subtraction becomes x + ~y + ~borrow, so sub and c_in are folded
         // into the operands here. They are not needed further down the pipe.
         assign x_in_s  = x;
         assign ye_in_s = y ^ {N{sub}};
         assign s_in_s  = {N{1'b0}};
         assign c_in_s  = c_in ^ sub;
         assign v_in_s  = in_valid & en_s;
      end else begin : g_body
         assign x_in_s  = g_stage[k-1].x_r;
         assign ye_in_s = g_stage[k-1].ye_r;
         assign s_in_s  = g_stage[k-1].s_r;
         assign c_in_s  = g_stage[k-1].c_r;
         assign v_in_s  = g_stage[k-1].v_r;
      end

      assign xa_s = x_in_s[k*W +: W];
      assign ya_s = ye_in_s[k*W +: W];

      // Ripple this stage's W-bit segment. The top bit is handled on its own
      // so that the carry into it is available for the overflow flag.
      always_comb begin
         logic carry_v;
         carry_v = c_in_s;
         seg_s   = {W{1'b0}};
         for (int i = 0; i < W - 1; i++) begin
            seg_s[i] = xa_s[i] ^ ya_s[i] ^ carry_v;
            carry_v  = (xa_s[i] & ya_s[i]) | (carry_v & (xa_s[i] ^ ya_s[i]));
         end
         msb_carry_s  = carry_v;
         seg_s[W-1]   = xa_s[W-1] ^ ya_s[W-1] ^ carry_v;
         cout_s       = (xa_s[W-1] & ya_s[W-1]) | (carry_v & (xa_s[W-1] ^ ya_s[W-1]));
         s_next_s            = s_in_s;
         s_next_s[k*W +: W]  = seg_s;
      end

      // Stage register: loads from its predecessor whenever the pipe advances.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r   <= 1'b0;
            x_r   <= {N{1'b0}};
            ye_r  <= {N{1'b0}};
            s_r   <= {N{1'b0}};
            c_r   <= 1'b0;
            ovf_r <= 1'b0;
         end else if (en_s) begin
            v_r   <= v_in_s;
            x_r   <= x_in_s;
            ye_r  <= ye_in_s;
            s_r   <= s_next_s;
            c_r   <= cout_s;
            ovf_r <= msb_carry_s ^ cout_s;
         end
      end

      // Operand bits already consumed and the overflow flag of inner
      // stages have no reader. They are collected here to show that this is intended.
      assign unused_s = ^{x_r, ye_r, ovf_r};
   end

   assign out_valid = g_stage[STAGES-1].v_r;
   assign s         = g_stage[STAGES-1].s_r;
   assign c_out     = g_stage[STAGES-1].c_r;
   assign ovf       = g_stage[STAGES-1].ovf_r;

endmodule
